// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the pipelined N-bit ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_MUL = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DONE     = 2'd2
    } state_e;

    // Bit positions inside flags = {overflow, carry, neg, zero}.
    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [W2-1:0]    mcand_q, acc_q, acc_d, addend;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, last;

    // The multiplier MSB carries weight -2^(WIDTH-1), so the final partial product is subtracted.
    always_comb begin
        last   = (cnt_q == CW'(WIDTH - 1));
        addend = '0;
        if (mplier_q[0]) addend = last ? -mcand_q : mcand_q;
        acc_d  = acc_q + addend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last) busy_q <= 1'b0;
        end
    end

    // done marks the cycle whose closing edge completes the product; product is that final sum.
    assign busy    = busy_q;
    assign done    = busy_q && last;
    assign product = acc_d;

endmodule

// File: rtl/alu_nbit_pipe.sv
// N-bit signed ALU with valid/ready handshakes; MUL runs on the iterative multiplier.
module alu_nbit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic                      cin,
    input  logic [2:0]                control,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] result,
    output logic [3:0]                flags
);
    localparam int W2 = 2 * WIDTH;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("alu_nbit_pipe: WIDTH must be in 2..32");
    end

    state_e           state_q;
    logic [W2-1:0]    result_q, alu_res, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] add_lo, sub_lo;
    logic [WIDTH:0]   add_s, sub_s;
    logic             add_c, sub_b, alu_c, alu_v;
    logic             accept, is_mul, mul_busy, mul_done;
    logic [W2-1:0]    mul_product;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (control == OP_MUL);
    assign result    = result_q;
    assign flags     = flags_q;

    // Bit WIDTH of the sign-extended sum equals sign(A) ^ sign(B) ^ unsigned carry/borrow out.
    always_comb begin
        {add_c, add_lo} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
        {sub_b, sub_lo} = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};
        add_s = {A[WIDTH-1] ^ B[WIDTH-1] ^ add_c, add_lo};
        sub_s = {A[WIDTH-1] ^ B[WIDTH-1] ^ sub_b, sub_lo};
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (control)
            OP_AND: alu_res = {{WIDTH{A[WIDTH-1] & B[WIDTH-1]}}, A & B};
            OP_OR:  alu_res = {{WIDTH{A[WIDTH-1] | B[WIDTH-1]}}, A | B};
            OP_XOR: alu_res = {{WIDTH{A[WIDTH-1] ^ B[WIDTH-1]}}, A ^ B};
            OP_NOT: alu_res = {{WIDTH{~A[WIDTH-1]}}, ~A};
            OP_ADD: begin
                alu_res = {{(WIDTH-1){add_s[WIDTH]}}, add_s};
                alu_c   = add_c;
                alu_v   = add_s[WIDTH] ^ add_s[WIDTH-1];
            end
            OP_SUB: begin
                alu_res = {{(WIDTH-1){sub_s[WIDTH]}}, sub_s};
                alu_c   = sub_b;
                alu_v   = sub_s[WIDTH] ^ sub_s[WIDTH-1];
            end
            default: begin
                // MUL never reaches this path's result; COMPARE lands here.
                if (A > B)       alu_res = W2'(1);
                else if (A == B) alu_res = '0;
                else             alu_res = '1;
            end
        endcase
    end

    always_comb begin
        res_d                = mul_done ? mul_product : alu_res;
        flags_d              = '0;
        flags_d[FLG_OVF]     = mul_done ? 1'b0 : alu_v;
        flags_d[FLG_CARRY]   = mul_done ? 1'b0 : alu_c;
        flags_d[FLG_NEG]     = res_d[W2-1];
        flags_d[FLG_ZERO]    = (res_d == '0);
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state_q)
                S_MUL_BUSY: begin
                    if (mul_done) begin
                        state_q  <= S_DONE;
                        result_q <= res_d;
                        flags_q  <= flags_d;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= S_MUL_BUSY;
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= res_d;
                            flags_q  <= flags_d;
                        end
                    end else if (state_q == S_DONE && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nbit_pipe.sv
// Self-checking bench for alu_nbit_pipe (WIDTH=8): directed vectors plus randomized ops vs. an integer model.
module tb_alu_nbit_pipe;
    localparam int W = 8;

    logic              clk, rst, in_valid, in_ready, cin, out_valid, out_ready;
    logic [2:0]        control;
    logic [W-1:0]      A, B;
    logic [2*W-1:0]    result;
    logic [3:0]        flags;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_res;
    logic [3:0]  last_flg;

    alu_nbit_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .control(control),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Returns {overflow, carry, neg, zero, result[15:0]} from plain integer arithmetic.
    function automatic logic [19:0] ref_op(input logic [2:0] op, input int a, input int b, input int ci);
        int r;
        logic c, v;
        logic [15:0] r16;
        c = 0;
        v = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~a;
            3'd4: begin
                r = a + b + ci;
                c = ((a & 255) + (b & 255) + ci) > 255;
                v = (r > 127) || (r < -128);
            end
            3'd5: begin
                r = a - b - ci;
                c = (a & 255) < ((b & 255) + ci);
                v = (r > 127) || (r < -128);
            end
            3'd6: r = a * b;
            default: r = (a > b) ? 1 : ((a == b) ? 0 : -1);
        endcase
        r16 = r[15:0];
        return {v, c, r16[15], (r16 == 16'h0), r16};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op from IDLE, checks latency/result/flags against the model, then drains it.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input string tag);
        logic [19:0] e;
        int n;
        logic rdy_seen;
        e = ref_op(op, $signed(a), $signed(b), int'(ci));
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1; control = op; A = a; B = b; cin = ci; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; A = 8'($urandom); B = 8'($urandom); control = 3'($urandom); cin = 1'($urandom);
        n = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) rdy_seen = 1;
        end while (!out_valid && n < 40);
        chk({tag, "_latency"}, n, (op == 3'd6) ? W + 1 : 1);
        chk({tag, "_busy_in_ready"}, rdy_seen, 0);
        chk({tag, "_result"}, result, e[15:0]);
        chk({tag, "_flags"}, flags, e[19:16]);
        last_res = result;
        last_flg = flags;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    logic [19:0] q[$];
    logic [19:0] e;
    logic [2:0]  rop;
    logic [7:0]  ra, rb;
    logic        rc, seen_v;

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; cin = 0; control = 0; A = 0; B = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Directed vectors.
        run_op(3'd4, 8'd100, 8'd27, 1'b1, "add_ovf");
        chk("add_ovf_const_res", last_res, 16'h0080);
        chk("add_ovf_const_flg", last_flg, 4'b1000);
        run_op(3'd6, 8'h80, 8'h80, 1'b0, "mul_minmin");
        chk("mul_minmin_const", last_res, 16'h4000);
        run_op(3'd5, 8'hFF, 8'd2, 1'b0, "sub_neg");
        chk("sub_neg_const_res", last_res, 16'hFFFD);
        chk("sub_neg_const_flg", last_flg, 4'b0010);
        run_op(3'd7, 8'hFF, 8'd2, 1'b0, "cmp_lt");
        chk("cmp_lt_const", last_res, 16'hFFFF);
        run_op(3'd7, 8'd5, 8'd5, 1'b0, "cmp_eq");
        run_op(3'd5, 8'h80, 8'd1, 1'b0, "sub_ovf");
        run_op(3'd4, 8'hFF, 8'h01, 1'b0, "add_carry");

        // Backpressure: result held stable while out_ready is low.
        @(negedge clk);
        in_valid = 1; control = 3'd2; A = 8'h5A; B = 8'hFF; cin = 0; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 16'hFFA5);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1; in_valid = 1; control = 3'd4; A = 8'd1; B = 8'd1; cin = 0;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 16'h0002);
        chk("bp_next_flags", flags, 4'b0000);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        in_valid = 1; control = 3'd6; A = 8'($urandom); B = 8'($urandom | 1); out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        seen_v = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_v = 1;
        end
        chk("midrst_no_result", seen_v, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result_hold", result, 0);
        out_ready = 0;
        run_op(3'd0, 8'hF0, 8'h3C, 1'b0, "and_after_rst");
        chk("and_const_res", last_res, 16'h0030);
        chk("and_const_zero", last_flg[0], 0);

        // Back-to-back non-MUL ops with continuous handshakes.
        out_ready = 1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q.pop_front();
                chk("b2b_out_valid", out_valid, 1);
                chk("b2b_result", result, e[15:0]);
                chk("b2b_flags", flags, e[19:16]);
            end
            if (i < 16) begin
                rop = 3'($urandom_range(0, 7));
                if (rop == 3'd6) rop = 3'd7;
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                in_valid = 1; control = rop; A = ra; B = rb; cin = rc;
                q.push_back(ref_op(rop, $signed(ra), $signed(rb), int'(rc)));
                #1;
                chk("b2b_in_ready", in_ready, 1);
            end else begin
                in_valid = 0;
            end
        end
        @(posedge clk); #1;
        out_ready = 0;

        // Random single ops, MUL included.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (i % 4 == 0) rop = 3'd6;
            run_op(rop, 8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
